// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: merges write-back sources A and B into one buffered register-file write channel.
// Define REGFILE_WB_RR_EN for round-robin arbitration; default build uses fixed priority (A wins).
module regfile_write_arbiter #(
    parameter int width = 32,
    parameter int n = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [n-1:0]     A_WRITE_INDEX,
    input  logic [width-1:0] A_WRITE_DATA,
    input  logic             A_WRITE_VALID,
    output logic             A_WRITE_CONSUMED,
    input  logic [n-1:0]     B_WRITE_INDEX,
    input  logic [width-1:0] B_WRITE_DATA,
    input  logic             B_WRITE_VALID,
    output logic             B_WRITE_CONSUMED,
    output logic             WRITE_EN_WRITE,
    output logic [n-1:0]     WRITE_INDEX_WRITE,
    output logic [width-1:0] WRITE_DATA_WRITE,
    output logic             WRITE_EN_WRITE_VALID,
    output logic             WRITE_INDEX_WRITE_VALID,
    output logic             WRITE_DATA_WRITE_VALID,
    input  logic             WRITE_EN_WRITE_CONSUMED,
    input  logic             WRITE_INDEX_WRITE_CONSUMED,
    input  logic             WRITE_DATA_WRITE_CONSUMED
);
    logic [n-1:0]     idx_q [2];
    logic [width-1:0] dat_q [2];
    logic             head, tail;
    logic [1:0]       count;
    logic             space, prefer_a, grant_a, grant_b, push, pop;

`ifdef REGFILE_WB_RR_EN
    logic last_b;
    // on conflict A wins only if B was granted last
    always_ff @(posedge CLK or posedge RST)
        if (RST) last_b <= 1'b1;
        else if (push) last_b <= grant_b;
    assign prefer_a = last_b;
`else
    assign prefer_a = 1'b1;
`endif

    // space comes from the registered count only, so downstream stalls never reach the sources combinationally
    always_comb begin
        space   = !RST && count != 2'd2;
        grant_a = space && A_WRITE_VALID && (!B_WRITE_VALID || prefer_a);
        grant_b = space && B_WRITE_VALID && (!A_WRITE_VALID || !prefer_a);
        push    = grant_a || grant_b;
        pop     = count != 2'd0 && WRITE_EN_WRITE_CONSUMED && WRITE_INDEX_WRITE_CONSUMED && WRITE_DATA_WRITE_CONSUMED;
    end

    assign A_WRITE_CONSUMED        = RST ? 1'b0 : (A_WRITE_VALID ? grant_a : 1'b1);
    assign B_WRITE_CONSUMED        = RST ? 1'b0 : (B_WRITE_VALID ? grant_b : 1'b1);
    assign WRITE_EN_WRITE          = 1'b1;
    assign WRITE_INDEX_WRITE       = idx_q[head];
    assign WRITE_DATA_WRITE        = dat_q[head];
    assign WRITE_EN_WRITE_VALID    = count != 2'd0;
    assign WRITE_INDEX_WRITE_VALID = count != 2'd0;
    assign WRITE_DATA_WRITE_VALID  = count != 2'd0;

    // two-entry FIFO: push at tail, pop at head; entries cleared on reset so outputs read 0
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                idx_q[i] <= '0;
                dat_q[i] <= '0;
            end
        end else begin
            if (push) begin
                idx_q[tail] <= grant_a ? A_WRITE_INDEX : B_WRITE_INDEX;
                dat_q[tail] <= grant_a ? A_WRITE_DATA : B_WRITE_DATA;
                tail        <= !tail;
            end
            if (pop) head <= !head;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vectors for the register-file write arbiter.
module tb_regfile_write_arbiter;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [4:0]  a_idx = '0, b_idx = '0, w_idx;
    logic [31:0] a_dat = '0, b_dat = '0, w_dat;
    logic        a_vld = 1'b0, b_vld = 1'b0, a_cns, b_cns;
    logic        w_en, v_en, v_idx, v_dat, cons = 1'b0;
    int          n_cmp = 0, n_bad = 0;

    regfile_write_arbiter dut (
        .CLK(CLK), .RST(RST),
        .A_WRITE_INDEX(a_idx), .A_WRITE_DATA(a_dat), .A_WRITE_VALID(a_vld), .A_WRITE_CONSUMED(a_cns),
        .B_WRITE_INDEX(b_idx), .B_WRITE_DATA(b_dat), .B_WRITE_VALID(b_vld), .B_WRITE_CONSUMED(b_cns),
        .WRITE_EN_WRITE(w_en), .WRITE_INDEX_WRITE(w_idx), .WRITE_DATA_WRITE(w_dat),
        .WRITE_EN_WRITE_VALID(v_en), .WRITE_INDEX_WRITE_VALID(v_idx), .WRITE_DATA_WRITE_VALID(v_dat),
        .WRITE_EN_WRITE_CONSUMED(cons), .WRITE_INDEX_WRITE_CONSUMED(cons), .WRITE_DATA_WRITE_CONSUMED(cons)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic va, input logic [4:0] ia, input logic [31:0] da,
                         input logic vb, input logic [4:0] ib, input logic [31:0] db);
        a_vld = va; a_idx = ia; a_dat = da;
        b_vld = vb; b_idx = ib; b_dat = db;
    endtask

    initial begin
        #3;
        check("rst_valid", {v_en, v_idx, v_dat}, 3'b000);
        check("rst_a_cons", a_cns, 1'b0);
        check("rst_b_cons", b_cns, 1'b0);
        check("rst_idx_dat", {w_idx, w_dat}, 37'd0);
        check("rst_en", w_en, 1'b1);
        tick;
        RST = 1'b0;

        cons = 1'b1;
        drive(1, 5'd3, 32'hDEADBEEF, 0, 0, 0);
        #1 check("t1_a_cons", a_cns, 1'b1);
        check("t1_b_cons_idle", b_cns, 1'b1);
        tick;
        check("t1_valid", {v_en, v_idx, v_dat}, 3'b111);
        check("t1_idx", w_idx, 5'd3);
        check("t1_dat", w_dat, 32'hDEADBEEF);
        check("t1_en", w_en, 1'b1);
        drive(0, 0, 0, 0, 0, 0);
        tick;
        check("t1_drain", v_en, 1'b0);

        cons = 1'b0;
        drive(1, 5'd1, 32'h11, 0, 0, 0);
        #1 check("t2_cons1", a_cns, 1'b1);
        tick;
        check("t2_head1", {v_en, w_idx}, {1'b1, 5'd1});
        drive(1, 5'd2, 32'h22, 0, 0, 0);
        #1 check("t2_cons2", a_cns, 1'b1);
        tick;
        check("t2_head1b", w_idx, 5'd1);
        drive(1, 5'd3, 32'h33, 0, 0, 0);
        #1 check("t2_full", a_cns, 1'b0);
        tick;
        check("t2_head1c", w_idx, 5'd1);
        check("t2_full_again", a_cns, 1'b0);
        cons = 1'b1;
        #1 check("t2_full_no_comb", a_cns, 1'b0);
        tick;
        check("t2_head2", {v_en, w_idx, w_dat}, {1'b1, 5'd2, 32'h22});
        check("t2_cons3", a_cns, 1'b1);
        tick;
        check("t2_pushpop_head3", {v_en, w_idx, w_dat}, {1'b1, 5'd3, 32'h33});
        drive(0, 0, 0, 0, 0, 0);
        tick;
        check("t2_empty", v_en, 1'b0);

        RST = 1'b1;
        #2 RST = 1'b0;
        cons = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic exp_b;
`ifdef REGFILE_WB_RR_EN
            exp_b = (i % 2) == 1;
`else
            exp_b = 1'b0;
`endif
            drive(1, 5'd10, 32'hA, 1, 5'd11, 32'hB);
            #1 check($sformatf("t3_a_cons%0d", i), a_cns, !exp_b);
            check($sformatf("t3_b_cons%0d", i), b_cns, exp_b);
            tick;
            check($sformatf("t3_idx%0d", i), w_idx, exp_b ? 5'd11 : 5'd10);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick;
        check("t3_empty", v_en, 1'b0);

        drive(1, 5'd5, 32'h1, 0, 0, 0);
        tick;
        check("t5_first", {v_en, w_idx, w_dat}, {1'b1, 5'd5, 32'h1});
        drive(0, 0, 0, 1, 5'd5, 32'h2);
        #1 check("t5_b_cons", b_cns, 1'b1);
        tick;
        check("t5_second", {v_en, w_idx, w_dat}, {1'b1, 5'd5, 32'h2});
        drive(0, 0, 0, 0, 0, 0);
        tick;
        check("t5_empty", v_en, 1'b0);

        cons = 1'b0;
        drive(1, 5'd7, 32'h7, 0, 0, 0);
        tick;
        drive(1, 5'd8, 32'h8, 0, 0, 0);
        tick;
        check("t6_full_head", {v_en, w_idx}, {1'b1, 5'd7});
        drive(0, 0, 0, 0, 0, 0);
        #2 RST = 1'b1;
        #1 check("t6_async_valid", {v_en, v_idx, v_dat}, 3'b000);
        check("t6_async_idx", w_idx, 5'd0);
        #1 RST = 1'b0;
        cons = 1'b1;
        drive(1, 5'd9, 32'h9, 0, 0, 0);
        tick;
        check("t6_new_first", {v_en, w_idx, w_dat}, {1'b1, 5'd9, 32'h9});
        drive(0, 0, 0, 0, 0, 0);
        tick;
        check("t6_no_stale", v_en, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
